// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parameterised UART transmitter with a transmit FIFO.
// Words enter through a valid/ready port, queue in the FIFO, and are
// shifted out LSB first as START, DATA, optional PARITY and STOP bits.
// Frames leave back to back with no idle gap while the FIFO holds words.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W        = 4;

  // Reject parameter sets the datapath cannot represent.
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_cfg: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];

  logic                   push;
  logic                   pop;
  logic                   bit_end;
  logic [DATA_BITS-1:0]   head_word;

  assign s_ready    = (count_q != CNT_W'(FIFO_DEPTH)) && !reset;
  assign push       = s_valid && s_ready;
  assign bit_end    = (baud_cnt_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign head_word  = mem_q[rd_ptr_q];
  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  // Frame sequencer plus FIFO bookkeeping; tx is the line level of the
  // current state delayed one cycle so every bit keeps its full width.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    pop        = 1'b0;

    if (state_q != ST_IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        tx_d = parity_q;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop) begin
      shift_d  = head_word;
      parity_d = (PARITY == 1) ? ~(^head_word) : ^head_word;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State, counters and FIFO storage; reset drops any queued or in-flight frame.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg. Four instances cover
// 8N1 with a 4-deep FIFO, 8E1, 8O1 and 7N2, all at 10 clocks per bit.
module tb_uart_tx_cfg;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset;

  logic [7:0] s_data_a, s_data_b, s_data_c;
  logic [6:0] s_data_d;
  logic [3:0] s_valid;
  logic [3:0] ready_w;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b, cnt_c, cnt_d;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .s_data(s_data_a), .s_valid(s_valid[0]),
    .s_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_a));

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .reset(reset), .s_data(s_data_b), .s_valid(s_valid[1]),
    .s_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_b));

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_c (
    .clk(clk), .reset(reset), .s_data(s_data_c), .s_valid(s_valid[2]),
    .s_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_c));

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_d (
    .clk(clk), .reset(reset), .s_data(s_data_d), .s_valid(s_valid[3]),
    .s_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_d));

  function automatic int cntOf(input int sel);
    case (sel)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      2:       return int'(cnt_c);
      default: return int'(cnt_d);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input int sel, input logic [7:0] data);
    case (sel)
      0:       s_data_a = data;
      1:       s_data_b = data;
      2:       s_data_c = data;
      default: s_data_d = data[6:0];
    endcase
  endtask

  // Offer one word for exactly one edge; returns just after that edge.
  task automatic applyStimulus(input int sel, input logic [7:0] data);
    setData(sel, data);
    s_valid[sel] = 1'b1;
    nextCycle();
    s_valid[sel] = 1'b0;
  endtask

  // Starting on the first cycle of the start bit, check that every bit slot
  // holds its expected level for all CPB cycles; ends on the cycle after.
  task automatic frameCheck(input int sel, input string tag,
                            input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int hits = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx_w[sel] == bits[i]) hits++;
        nextCycle();
      end
      checkOutput($sformatf("%s.bit%0d", tag, i), hits, CPB);
    end
  endtask

  task automatic waitStart(input int sel, input string tag, input int maxc);
    int n = 0;
    while (tx_w[sel] != 1'b0 && n < maxc) begin
      nextCycle();
      n++;
    end
    if (tx_w[sel] != 1'b0) checkOutput({tag, ".startTimeout"}, 0, 1);
  endtask

  // Push one word into an idle instance and verify latency, frame and idle.
  task automatic singleFrame(input int sel, input string tag, input logic [7:0] data,
                             input logic [15:0] bits, input int nbits);
    applyStimulus(sel, data);
    checkOutput({tag, ".countAfterPush"}, cntOf(sel), 1);
    nextCycle();
    checkOutput({tag, ".txHighN1"}, int'(tx_w[sel]), 1);
    checkOutput({tag, ".busyN1"}, int'(busy_w[sel]), 1);
    nextCycle();
    frameCheck(sel, tag, bits, nbits);
    checkOutput({tag, ".txIdleAfter"}, int'(tx_w[sel]), 1);
    checkOutput({tag, ".busyAfter"}, int'(busy_w[sel]), 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] words [6];
    words[0] = 8'h01; words[1] = 8'hA5; words[2] = 8'h3C;
    words[3] = 8'hFF; words[4] = 8'h80; words[5] = 8'h5A;

    reset    = 1'b1;
    s_valid  = '0;
    s_data_a = '0; s_data_b = '0; s_data_c = '0; s_data_d = '0;
    repeat (3) nextCycle();

    $display("[TB] reset state");
    checkOutput("rst.tx", int'(tx_w[0]), 1);
    checkOutput("rst.busy", int'(busy_w[0]), 0);
    checkOutput("rst.count", cntOf(0), 0);
    checkOutput("rst.readyLow", int'(ready_w[0]), 0);
    reset = 1'b0;
    nextCycle();
    checkOutput("rst.readyHigh", int'(ready_w[0]), 1);
    checkOutput("rst.readyHighB", int'(ready_w[1]), 1);

    $display("[TB] single frames");
    singleFrame(0, "8n1_55", 8'h55, 16'b0000_0010_1010_1010, 10);
    singleFrame(1, "8e1_07", 8'h07, 16'b0000_0110_0000_1110, 11);
    singleFrame(2, "8o1_07", 8'h07, 16'b0000_0100_0000_1110, 11);
    singleFrame(3, "7n2_41", 8'h41, 16'b0000_0011_1000_0010, 10);

    $display("[TB] back-to-back frames through 4-deep FIFO");
    fork
      begin
        int k = 0;
        int guard = 0;
        bit sawFull = 0;
        logic rdy;
        s_valid[0] = 1'b1;
        while (k < 6 && guard < 800) begin
          setData(0, words[k]);
          rdy = ready_w[0];
          nextCycle();
          guard++;
          if (rdy) k++;
          if (cnt_a == 3'd4 && !sawFull) begin
            checkOutput("fifo.readyAtFull", int'(ready_w[0]), 0);
            sawFull = 1;
          end
        end
        s_valid[0] = 1'b0;
        checkOutput("fifo.allPushed", k, 6);
        checkOutput("fifo.sawFull", int'(sawFull), 1);
      end
      begin
        waitStart(0, "fifo", 10);
        for (int f = 0; f < 6; f++) begin
          frameCheck(0, $sformatf("fifo.f%0d", f), {6'b0, 1'b1, words[f], 1'b0}, 10);
        end
        checkOutput("fifo.txIdleAfter", int'(tx_w[0]), 1);
        checkOutput("fifo.busyAfter", int'(busy_w[0]), 0);
        checkOutput("fifo.countAfter", cntOf(0), 0);
      end
    join

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'hA5);
    applyStimulus(0, 8'h3C);
    applyStimulus(0, 8'hC3);
    checkOutput("rmid.queued", cntOf(0), 2);
    repeat (42) nextCycle();
    checkOutput("rmid.txBit3", int'(tx_w[0]), 0);
    reset = 1'b1;
    nextCycle();
    checkOutput("rmid.tx", int'(tx_w[0]), 1);
    checkOutput("rmid.busy", int'(busy_w[0]), 0);
    checkOutput("rmid.count", cntOf(0), 0);
    checkOutput("rmid.readyLow", int'(ready_w[0]), 0);
    reset = 1'b0;
    nextCycle();
    checkOutput("rmid.readyHigh", int'(ready_w[0]), 1);
    begin
      int lowCycles = 0;
      int busyCycles = 0;
      for (int i = 0; i < 150; i++) begin
        if (tx_w[0] == 1'b0) lowCycles++;
        if (busy_w[0] == 1'b1) busyCycles++;
        nextCycle();
      end
      checkOutput("rmid.noFrame", lowCycles, 0);
      checkOutput("rmid.noBusy", busyCycles, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
